// File: rtl/ask2_ext_bus_ctrl.sv
// ask2_ext_bus_ctrl
// Bridges an Avalon-MM slave port to an 8-bit asynchronous external bus
// with programmable setup, strobe and hold times.
//
// Ports:
//   clk, reset_n       clock (rising edge), asynchronous active-low reset
//   address            word address, latched and driven on ext_a
//   chipselect, read_n, write_n, writedata[7:0]   Avalon request
//   readdata           {24'b0, byte captured on the last strobe cycle}
//   waitrequest        Avalon stall
//   ext_a, ext_cs_n, ext_rd_n, ext_wr_n            external control
//   ext_d_out, ext_d_oe, ext_d_in                  external data bus
//   ext_wait_n         (only with ASK2_EXT_WAIT_EN) device wait input
//
// Optional feature macro: ASK2_EXT_WAIT_EN. When defined, STROBE is
// stretched while ext_wait_n is sampled low after the programmed strobe
// count has expired, for at most 255 extra cycles. On timeout the strobe
// ends and a read returns 0xFF.
//
// Handshake: a request is chipselect & (~read_n | ~write_n). The master
// holds the request until it sees waitrequest low; waitrequest is
// request & ~done, where done is high only in the final HOLD cycle. Both
// strobes low counts as a write. The request is sampled only in IDLE, so
// consecutive transactions are separated by at least one IDLE cycle.
module ask2_ext_bus_ctrl #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  ext_a,
  output logic        ext_cs_n,
  output logic        ext_rd_n,
  output logic        ext_wr_n,
  output logic [7:0]  ext_d_out,
  output logic        ext_d_oe,
`ifdef ASK2_EXT_WAIT_EN
  input  logic        ext_wait_n,
`endif
  input  logic [7:0]  ext_d_in
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // Counters are loaded with N-1 and the state exits when they reach 0.
  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       op_wr;
  logic       done;
  logic       request;
  logic       stretch;
  logic [7:0] rd_byte;

  assign request     = chipselect & (~read_n | ~write_n);
  assign waitrequest = request & ~done;

`ifdef ASK2_EXT_WAIT_EN
  logic [7:0] wait_cnt;
  assign stretch = ~ext_wait_n & (wait_cnt != 8'hFF);
  // Still waiting when the stretch budget is used up means timeout.
  assign rd_byte = ext_wait_n ? ext_d_in : 8'hFF;
`else
  assign stretch = 1'b0;
  assign rd_byte = ext_d_in;
`endif

  // Upper write bytes are not used by an 8-bit bus.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      op_wr     <= 1'b0;
      done      <= 1'b0;
      ext_a     <= 2'd0;
      ext_cs_n  <= 1'b1;
      ext_rd_n  <= 1'b1;
      ext_wr_n  <= 1'b1;
      ext_d_out <= 8'h00;
      ext_d_oe  <= 1'b0;
      readdata  <= 32'd0;
`ifdef ASK2_EXT_WAIT_EN
      wait_cnt  <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            ext_a    <= address;
            op_wr    <= ~write_n;
            ext_cs_n <= 1'b0;
            if (!write_n) begin
              ext_d_out <= writedata[7:0];
              ext_d_oe  <= 1'b1;
            end
            cnt   <= SETUP_LD;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            ext_rd_n <= op_wr;
            ext_wr_n <= ~op_wr;
            cnt      <= STROBE_LD;
            state    <= STROBE;
`ifdef ASK2_EXT_WAIT_EN
            wait_cnt <= 8'd0;
`endif
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        STROBE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (stretch) begin
`ifdef ASK2_EXT_WAIT_EN
            wait_cnt <= wait_cnt + 8'd1;
`endif
          end else begin
            ext_rd_n <= 1'b1;
            ext_wr_n <= 1'b1;
            if (!op_wr) readdata <= {24'd0, rd_byte};
            cnt   <= HOLD_LD;
            done  <= (HOLD_LD == 8'd0);
            state <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            ext_cs_n <= 1'b1;
            ext_d_oe <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt  <= cnt - 8'd1;
            // Next cycle is the last HOLD cycle.
            done <= (cnt == 8'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
